// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment display controller: hex or sequential double-dabble decimal conversion,
// per-digit decimal points, leading-zero blanking. Optional digit blinking under `SEG_BLINK_EN`.
`timescale 1ns/1ps
module seg_scan_ctrl #(
   parameter int DATA_W    = 32,
   parameter int DIGITS    = 8,
   parameter int SCAN_DIV  = 150000,
   parameter int BLINK_DIV = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              mode,
   input  logic [DATA_W-1:0] data,
   input  logic [DIGITS-1:0] dp,
   input  logic              blank_lz,
`ifdef SEG_BLINK_EN
   input  logic [DIGITS-1:0] blink_mask,
`endif
   output logic              busy,
   output logic [7:0]        seg,
   output logic [DIGITS-1:0] an
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int PRE_W = $clog2(SCAN_DIV + 1);
   localparam int POS_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   if (DIGITS < 1 || DIGITS > 8 || SCAN_DIV < 1 || BLINK_DIV < 1 || DATA_W < 2) begin : g_bad_param
      $error("seg_scan_ctrl: parameter out of range");
   end

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;  4'h9: glyph = 7'h18;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
      endcase
   endfunction

   // Add-3 correction on every nibble, then shift one data bit in; the top carry falls off.
   function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b, input logic bit_in);
      logic [BCD_W-1:0] a;
      a = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (b[4*i +: 4] >= 4'd5) a[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
      return {a[BCD_W-2:0], bit_in};
   endfunction

   logic              busy_q, busy_d;
   logic              mode_q, mode_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_n;
   logic [DIGITS-1:0] pdp_q, pdp_d;
   logic              pblz_q, pblz_d;
   logic [BCD_W-1:0]  dig_q, dig_d;
   logic [DIGITS-1:0] dp_q, dp_d;
   logic              blz_q, blz_d;
   logic [PRE_W-1:0]  presc_q, presc_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic [7:0]        seg_q, seg_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [DIGITS-1:0] blank;
   logic              zero_run;
`ifdef SEG_BLINK_EN
   localparam int FRM_W = $clog2(BLINK_DIV + 1);
   logic [DIGITS-1:0] pbm_q, pbm_d, bm_q, bm_d;
   logic [FRM_W-1:0]  frame_q, frame_d;
   logic              phase_q, phase_d;
`endif

   always_comb begin
      busy_d  = busy_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      bcd_d   = bcd_q;
      pdp_d   = pdp_q;
      pblz_d  = pblz_q;
      dig_d   = dig_q;
      dp_d    = dp_q;
      blz_d   = blz_q;
      bcd_n   = dd_step(bcd_q, shreg_q[DATA_W-1]);
`ifdef SEG_BLINK_EN
      pbm_d   = pbm_q;
      bm_d    = bm_q;
`endif
      if (load && !busy_q) begin
         busy_d  = 1'b1;
         mode_d  = mode;
         cnt_d   = '0;
         shreg_d = data;
         bcd_d   = '0;
         pdp_d   = dp;
         pblz_d  = blank_lz;
`ifdef SEG_BLINK_EN
         pbm_d   = blink_mask;
`endif
      end else if (busy_q) begin
         if (mode_q) begin
            busy_d = 1'b0;
            dig_d  = BCD_W'(shreg_q);
            dp_d   = pdp_q;
            blz_d  = pblz_q;
`ifdef SEG_BLINK_EN
            bm_d   = pbm_q;
`endif
         end else begin
            bcd_d   = bcd_n;
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
               busy_d = 1'b0;
               dig_d  = bcd_n;
               dp_d   = pdp_q;
               blz_d  = pblz_q;
`ifdef SEG_BLINK_EN
               bm_d   = pbm_q;
`endif
            end
         end
      end

      presc_d = presc_q + 1'b1;
      pos_d   = pos_q;
      if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
         presc_d = '0;
         pos_d   = (pos_q == POS_W'(DIGITS - 1)) ? '0 : pos_q + 1'b1;
      end

      // A digit is blank when it and every digit above it are zero; digit 0 always shows.
      blank    = '0;
      zero_run = blz_q;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run = zero_run && (dig_q[4*i +: 4] == 4'h0);
         blank[i] = zero_run;
      end

      seg_d = {~dp_q[pos_d], blank[pos_d] ? 7'h7F : glyph(dig_q[4*pos_d +: 4])};
      an_d  = ~(DIGITS'(1) << pos_d);
`ifdef SEG_BLINK_EN
      frame_d = frame_q;
      phase_d = phase_q;
      if (presc_q == PRE_W'(SCAN_DIV - 1) && pos_q == POS_W'(DIGITS - 1)) begin
         if (frame_q == FRM_W'(BLINK_DIV - 1)) begin
            frame_d = '0;
            phase_d = ~phase_q;
         end else begin
            frame_d = frame_q + 1'b1;
         end
      end
      if (!phase_d && bm_q[pos_d]) an_d = '1;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= 1'b0;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
         shreg_q <= '0;
         bcd_q   <= '0;
         pdp_q   <= '0;
         pblz_q  <= 1'b0;
         dig_q   <= '0;
         dp_q    <= '0;
         blz_q   <= 1'b0;
         presc_q <= '0;
         pos_q   <= '0;
         seg_q   <= 8'hFF;
         an_q    <= '1;
`ifdef SEG_BLINK_EN
         pbm_q   <= '0;
         bm_q    <= '0;
         frame_q <= '0;
         phase_q <= 1'b1;
`endif
      end else begin
         busy_q  <= busy_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         bcd_q   <= bcd_d;
         pdp_q   <= pdp_d;
         pblz_q  <= pblz_d;
         dig_q   <= dig_d;
         dp_q    <= dp_d;
         blz_q   <= blz_d;
         presc_q <= presc_d;
         pos_q   <= pos_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
`ifdef SEG_BLINK_EN
         pbm_q   <= pbm_d;
         bm_q    <= bm_d;
         frame_q <= frame_d;
         phase_q <= phase_d;
`endif
      end
   end

   assign busy = busy_q;
   assign seg  = seg_q;
   assign an   = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: loads push expected digit images, a monitor checks
// busy length and every scanned digit once each conversion completes.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
   localparam int DATA_W   = 32;
   localparam int DIGITS   = 8;
   localparam int SCAN_DIV = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              load = 1'b0;
   logic              mode = 1'b0;
   logic [DATA_W-1:0] data = '0;
   logic [DIGITS-1:0] dp = '0;
   logic              blank_lz = 1'b0;
   logic              busy;
   logic [7:0]        seg;
   logic [DIGITS-1:0] an;

   seg_scan_ctrl #(.DATA_W(DATA_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(4)) dut (
      .clk(clk), .rst(rst), .load(load), .mode(mode), .data(data), .dp(dp),
      .blank_lz(blank_lz), .busy(busy), .seg(seg), .an(an)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DIGITS-1:0][7:0] seg;
      int                     blen;
      string                  name;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;
   int   done_cnt = 0;
   int   exp_n = 0;
   bit   mon_en = 1'b0;

   function automatic logic [6:0] ref_glyph(int v);
      case (v)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h18; 10: return 7'h08; 11: return 7'h03;
        12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
      endcase
   endfunction

   // Reference: plain arithmetic on the value, then glyph lookup and blanking by highest non-zero digit.
   function automatic exp_t model(bit m, logic [DATA_W-1:0] d, logic [DIGITS-1:0] dpv, bit blz, string nm);
      exp_t e;
      longint unsigned v, p10;
      int dig[DIGITS];
      int hi;
      p10 = 1;
      for (int i = 0; i < DIGITS; i++) p10 = p10 * 10;
      v = {32'b0, d};
      if (!m) v = v % p10;
      for (int i = 0; i < DIGITS; i++) begin
         if (m) begin
            dig[i] = int'((v >> (4 * i)) & 64'hF);
         end else begin
            dig[i] = int'(v % 10);
            v = v / 10;
         end
      end
      hi = 0;
      for (int i = 0; i < DIGITS; i++) if (dig[i] != 0) hi = i;
      for (int i = 0; i < DIGITS; i++)
         e.seg[i] = {~dpv[i], (blz && i > hi) ? 7'h7F : ref_glyph(dig[i])};
      e.blen = m ? 1 : DATA_W;
      e.name = nm;
      return e;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   task automatic check_frame(logic [DIGITS-1:0][7:0] exp, string nm);
      logic [DIGITS-1:0] seen;
      int p;
      bit bad_an;
      seen = '0;
      bad_an = 1'b0;
      for (int k = 0; k < (DIGITS + 1) * SCAN_DIV; k++) begin
         @(negedge clk);
         p = -1;
         for (int i = 0; i < DIGITS; i++) if (an == ~(DIGITS'(1) << i)) p = i;
         if (p < 0) begin
            if (!bad_an) begin
               checks++;
               errors++;
               $display("FAIL %s an one-hot: got %0h", nm, an);
            end
            bad_an = 1'b1;
         end else if (!seen[p]) begin
            seen[p] = 1'b1;
            chk($sformatf("%s pos%0d seg", nm, p), 32'(seg), 32'(exp[p]));
         end
      end
      chk({nm, " all positions scanned"}, 32'(seen), 32'hFF);
   endtask

   // Monitor: a busy pulse is the DUT presenting a result; pop and compare.
   initial begin : monitor
      int   len;
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && busy) begin
            len = 0;
            while (busy && len < 200) begin
               len++;
               @(negedge clk);
            end
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected conversion: busy rose with nothing pending (len %0d)", len);
            end else begin
               e = sb_q.pop_front();
               chk({e.name, " busy cycles"}, 32'(len), 32'(e.blen));
               @(negedge clk);
               check_frame(e.seg, e.name);
            end
            done_cnt++;
         end
      end
   end

   task automatic do_load(bit m, logic [DATA_W-1:0] d, logic [DIGITS-1:0] dpv, bit blz, string nm, bit push);
      @(posedge clk); #1;
      mode = m; data = d; dp = dpv; blank_lz = blz; load = 1'b1;
      if (push) begin
         sb_q.push_back(model(m, d, dpv, blz, nm));
         exp_n++;
      end
      @(posedge clk); #1;
      load = 1'b0;
      data = $urandom; dp = DIGITS'($urandom); mode = ~m; blank_lz = ~blz;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (done_cnt < exp_n && t < 1000) begin
         @(posedge clk);
         t++;
      end
      if (done_cnt < exp_n) begin
         checks++;
         errors++;
         $display("FAIL timeout waiting for result: got %0d done, expected %0d", done_cnt, exp_n);
         done_cnt = exp_n;
      end
   endtask

   task automatic issue(bit m, logic [DATA_W-1:0] d, logic [DIGITS-1:0] dpv, bit blz, string nm);
      do_load(m, d, dpv, blz, nm, 1'b1);
      wait_done();
   endtask

   initial begin : stimulus
      int t;
      logic [DATA_W-1:0] rd;
      logic [DIGITS-1:0][7:0] zeros;
      repeat (3) @(posedge clk);
      #1;
      chk("reset seg", 32'(seg), 32'hFF);
      chk("reset an", 32'(an), 32'hFF);
      chk("reset busy", 32'(busy), 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("an after release", 32'(an), 32'hFE);
      repeat (3) @(posedge clk);
      #1;
      chk("an 4 clk after release", 32'(an), 32'hFD);
      mon_en = 1'b1;

      issue(1'b1, 32'hDEADBEEF, 8'h00, 1'b0, "hex DEADBEEF");
      issue(1'b0, 32'd12345678, 8'h00, 1'b0, "dec 12345678");
      issue(1'b0, 32'hFFFFFFFF, 8'h01, 1'b0, "dec FFFFFFFF dp0");
      issue(1'b0, 32'd42, 8'h00, 1'b1, "dec 42 blank");
      issue(1'b0, 32'd0, 8'h00, 1'b1, "dec 0 blank");
      issue(1'b1, 32'h00000A00, 8'h84, 1'b1, "hex blank with dp");

      // Hold load high through the whole conversion, including its final cycle: all dropped.
      do_load(1'b0, 32'd90210, 8'h22, 1'b1, "dec drop-test", 1'b1);
      mode = 1'b1; data = 32'h0BADF00D; load = 1'b1;
      t = 0;
      while (busy && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      load = 1'b0;
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL drop-test busy stuck: got busy=1 after %0d cycles", t);
      end
      wait_done();

      for (int n = 0; n < 14; n++) begin
         case ($urandom_range(0, 3))
            0: rd = DATA_W'($urandom_range(0, 999));
            1: rd = $urandom >> $urandom_range(0, 31);
            default: rd = $urandom;
         endcase
         issue(1'(($urandom_range(0, 1))), rd, DIGITS'($urandom), 1'($urandom_range(0, 1)),
               $sformatf("rand%0d", n));
      end

      issue(1'b1, 32'h13579BDF, 8'h00, 1'b0, "hex before abort");
      mon_en = 1'b0;
      do_load(1'b0, 32'd87654321, 8'hFF, 1'b0, "abort", 1'b0);
      repeat (9) @(posedge clk);
      #1;
      chk("busy mid conversion", 32'(busy), 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("busy after abort", 32'(busy), 32'h0);
      @(posedge clk);
      for (int i = 0; i < DIGITS; i++) zeros[i] = {1'b1, ref_glyph(0)};
      check_frame(zeros, "after abort");
      chk("busy stays low after abort", 32'(busy), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
